reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-cycle core's 2R/1W register file.
- Adds: configurable width, depth and port counts; hardwired-zero register 0; asynchronous clear; write-to-read bypass; write-port priority.
- Adds a per-register busy scoreboard: decode marks a destination busy, writeback clears it. Intended for multi-issue and pipelined cores.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers (2..64).
- AW, 5, address width; must satisfy 2^AW >= NREG.
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read data; 0 = read returns the stored value.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  output  NRD  bit i = register addressed by ra port i has a pending write.
- we  input  NWR  per-port write enables.
- wa  input  NWR*AW  write addresses.
- wd  input  NWR*XLEN  write data.
- sb_set  input  1  mark register sb_addr busy.
- sb_addr  input  AW  scoreboard set address.
- busy_any  output  1  OR of all busy bits.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - All registers clear to 0 and all busy bits clear to 0.
  - Hence rd = 0, rd_busy = 0, busy_any = 0 while reset is held.
  - Release is synchronous-safe: first update happens on the first rising clk edge with rst_n=1.
- Reads are combinational, with zero latency.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - sb_set to it is dropped, so busy[0] stays 0.
- Out-of-range addresses (>= NREG):
  - Reads return 0 and rd_busy = 0.
  - Writes and sb_set to them are dropped.
- Write at posedge: reg[wa[j]] <= wd[j] for each j with we[j]=1 and a valid, nonzero wa[j].
- Write conflict (NWR=2, both enabled, same address): port 1 wins. Port 0's data is discarded and never visible.
- Bypass (BYPASS=1):
  - Applies when a read address matches an enabled valid nonzero write address in the same cycle.
  - rd returns the winning wd (port 1 over port 0) combinationally.
  - With BYPASS=0, rd returns the old stored value; the new value is visible from the next cycle.
- Scoreboard, at posedge:
  - Every performed write clears busy[wa[j]].
  - sb_set=1 sets busy[sb_addr].
  - Set and clear to the same address in the same cycle: set wins, so busy stays 1 (new producer issued).
  - sb_set to an already-busy register leaves it busy; no counting.
- rd_busy:
  - rd_busy[i] = busy[ra[i]], except when BYPASS=1 and an enabled write to ra[i] occurs this cycle; then rd_busy[i] = 0 because the data is being forwarded.
  - sb_set does not affect rd_busy combinationally; it takes effect next cycle.
- busy_any is a registered OR: it reflects busy state after the last edge.
- Reset mid-operation: contents and busy bits are lost immediately. Any pending write on that edge is not performed.
- Reset state is not valid X: every storage element has a defined reset value.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst_n=0 between clock edges -> rd for ra=5 reads 0 immediately; after release rd_busy=0 and busy_any=0.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF, sb_set=1, sb_addr=0 -> ra=0 reads 0 on the next cycle; rd_busy=0; busy_any=0.
- Bypass vs stored (BYPASS=1): r7 holds 0x11; same cycle we=1, wa=7, wd=0x22, ra=7 -> rd=0x22 in that cycle. With BYPASS=0 the same stimulus gives rd=0x11, then 0x22 next cycle.
- Dual-write conflict (NWR=2): both ports write r9 with 0xAAAA (port 0) and 0x5555 (port 1) -> r9 reads 0x5555 afterwards; bypass output in that cycle is also 0x5555.
- Scoreboard lifecycle:
  - sb_set r12 at cycle 0 -> rd_busy=1 for ra=12 from cycle 1 and busy_any=1.
  - At cycle 3, write r12=0x3 -> rd_busy=0 in cycle 3 (bypass) and thereafter; busy_any=0 from cycle 4.
- Set/clear collision: r4 busy; same cycle write r4=0x9 and sb_set r4 -> r4 reads 0x9 and rd_busy stays 1 afterwards.

Source files
------------

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file with hardwired r0, write bypass,
//            write-port priority and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic                busy_any
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_busy_any;
    logic [NREG-1:0] w_busy_nxt;

    logic [NWR-1:0]  w_wr_en;
    logic [AW-1:0]   w_wa [NWR];
    logic [XLEN-1:0] w_wd [NWR];

    // Valid means in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(NREG)) && (a != '0);
    endfunction

    generate
        for (genvar j = 0; j < NWR; j++) begin : g_wr
            assign w_wa[j]    = wa[j*AW +: AW];
            assign w_wd[j]    = wd[j*XLEN +: XLEN];
            assign w_wr_en[j] = we[j] && addr_ok(w_wa[j]);
        end
    endgenerate

    // Later ports are applied last, so the highest-numbered port wins a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NREG; k++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (w_wr_en[j] && (w_wa[j] == AW'(k))) begin
                        r_regs[k] <= w_wd[j];
                    end
                end
            end
        end
    end

    // Set is applied after clear so a new producer keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 1; k < NREG; k++) begin
            for (int j = 0; j < NWR; j++) begin
                if (w_wr_en[j] && (w_wa[j] == AW'(k))) begin
                    w_busy_nxt[k] = 1'b0;
                end
            end
            if (sb_set && addr_ok(sb_addr) && (sb_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_any <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_any <= |w_busy_nxt;
        end
    end

    assign busy_any = r_busy_any;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_stored;
            logic [XLEN-1:0] w_fwd;
            logic            w_hit;
            logic            w_busy_rd;

            assign w_ra = ra[i*AW +: AW];

            always_comb begin
                w_stored  = '0;
                w_busy_rd = 1'b0;
                for (int k = 1; k < NREG; k++) begin
                    if (w_ra == AW'(k)) begin
                        w_stored  = r_regs[k];
                        w_busy_rd = r_busy[k];
                    end
                end
                w_hit = 1'b0;
                w_fwd = '0;
                for (int j = 0; j < NWR; j++) begin
                    if (w_wr_en[j] && (w_wa[j] == w_ra)) begin
                        w_hit = 1'b1;
                        w_fwd = w_wd[j];
                    end
                end
            end

            assign rd[i*XLEN +: XLEN] = ((BYPASS != 0) && w_hit) ? w_fwd : w_stored;
            assign rd_busy[i]         = w_busy_rd && !((BYPASS != 0) && w_hit);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp (bypass and non-bypass copies).
// Revision : 1.0
// ============================================================================
module tb_reg_file_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        busy_any;
    logic [63:0] rd_nb;
    logic [1:0]  rd_busy_nb;
    logic        busy_any_nb;

    reg_file_mp #(
        .XLEN(32), .NREG(24), .AW(5), .NRD(2), .NWR(2), .BYPASS(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy_any(busy_any)
    );

    reg_file_mp #(
        .XLEN(32), .NREG(24), .AW(5), .NRD(2), .NWR(2), .BYPASS(0)
    ) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb),
        .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy_any(busy_any_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 rd0, 1 rd1, 2 rd_busy0, 3 rd_busy1, 4 busy_any, 5 nb rd0, 6 nb rd_busy0
    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push_exp(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0:       return rd[31:0];
            1:       return rd[63:32];
            2:       return {31'b0, rd_busy[0]};
            3:       return {31'b0, rd_busy[1]};
            4:       return {31'b0, busy_any};
            5:       return rd_nb[31:0];
            6:       return {31'b0, rd_busy_nb[0]};
            default: return 'x;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e.kind);
            n_checks++;
            if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = '0;
        wa      = '0;
        wd      = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ra    = '0;
        idle();
        cyc();
        ra[4:0] = 5'd5; ra[9:5] = 5'd6;
        push_exp(0, 32'h0, "reset_rd0");
        push_exp(3, 32'h0, "reset_rd_busy1");
        push_exp(4, 32'h0, "reset_busy_any");

        // Write r5 and mark r6 busy, then reset asynchronously.
        cyc();
        rst_n = 1'b1;
        we[0] = 1'b1; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF;
        sb_set = 1'b1; sb_addr = 5'd6;
        push_exp(0, 32'hDEADBEEF, "bypass_r5");
        push_exp(5, 32'h0,        "nb_old_r5");
        push_exp(3, 32'h0,        "sb_not_comb");
        push_exp(4, 32'h0,        "busy_any_pre");
        cyc();
        idle();
        push_exp(0, 32'hDEADBEEF, "stored_r5");
        push_exp(5, 32'hDEADBEEF, "nb_stored_r5");
        push_exp(3, 32'h1,        "busy_r6");
        push_exp(4, 32'h1,        "busy_any_r6");
        cyc();
        rst_n = 1'b0;
        push_exp(0, 32'h0, "async_rst_rd0");
        push_exp(5, 32'h0, "async_rst_nb_rd0");
        push_exp(3, 32'h0, "async_rst_busy1");
        push_exp(4, 32'h0, "async_rst_any");
        cyc();
        rst_n = 1'b1;
        push_exp(0, 32'h0, "post_rst_rd0");
        push_exp(3, 32'h0, "post_rst_busy1");
        push_exp(4, 32'h0, "post_rst_any");

        // Zero register ignores writes and scoreboard sets.
        cyc();
        we[0] = 1'b1; wa[4:0] = 5'd0; wd[31:0] = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd0; ra[4:0] = 5'd0;
        push_exp(0, 32'h0, "r0_no_bypass");
        push_exp(2, 32'h0, "r0_busy_same");
        cyc();
        idle();
        push_exp(0, 32'h0, "r0_reads_zero");
        push_exp(2, 32'h0, "r0_not_busy");
        push_exp(4, 32'h0, "r0_busy_any");

        // Bypass versus stored value.
        cyc();
        we[0] = 1'b1; wa[4:0] = 5'd7; wd[31:0] = 32'h11; ra[4:0] = 5'd7;
        cyc();
        wd[31:0] = 32'h22;
        push_exp(0, 32'h22, "bypass_r7");
        push_exp(5, 32'h11, "nb_old_r7");
        cyc();
        idle();
        push_exp(0, 32'h22, "stored_r7");
        push_exp(5, 32'h22, "nb_new_r7");

        // Dual-port write conflict: port 1 wins.
        cyc();
        we = 2'b11; wa[4:0] = 5'd9; wa[9:5] = 5'd9;
        wd[31:0] = 32'hAAAA; wd[63:32] = 32'h5555; ra[4:0] = 5'd9;
        push_exp(0, 32'h5555, "conflict_bypass");
        push_exp(5, 32'h0,    "conflict_nb_old");
        cyc();
        idle();
        push_exp(0, 32'h5555, "conflict_stored");
        push_exp(5, 32'h5555, "conflict_nb_stored");

        // Scoreboard lifecycle on r12.
        cyc();
        sb_set = 1'b1; sb_addr = 5'd12; ra[9:5] = 5'd12;
        push_exp(3, 32'h0, "sb_c0_busy");
        push_exp(4, 32'h0, "sb_c0_any");
        cyc();
        idle();
        push_exp(3, 32'h1, "sb_c1_busy");
        push_exp(4, 32'h1, "sb_c1_any");
        cyc();
        push_exp(3, 32'h1, "sb_c2_busy");
        cyc();
        we[0] = 1'b1; wa[4:0] = 5'd12; wd[31:0] = 32'h3;
        push_exp(3, 32'h0, "sb_c3_busy_fwd");
        push_exp(1, 32'h3, "sb_c3_rd1");
        push_exp(4, 32'h1, "sb_c3_any");
        cyc();
        idle();
        push_exp(3, 32'h0, "sb_c4_busy");
        push_exp(1, 32'h3, "sb_c4_rd1");
        push_exp(4, 32'h0, "sb_c4_any");

        // Set/clear collision on r4: set wins.
        cyc();
        sb_set = 1'b1; sb_addr = 5'd4; ra[4:0] = 5'd4;
        cyc();
        we[0] = 1'b1; wa[4:0] = 5'd4; wd[31:0] = 32'h9;
        push_exp(0, 32'h9, "coll_bypass");
        push_exp(2, 32'h0, "coll_busy_fwd");
        push_exp(6, 32'h1, "coll_nb_busy");
        cyc();
        idle();
        push_exp(0, 32'h9, "coll_stored");
        push_exp(2, 32'h1, "coll_busy_kept");
        push_exp(4, 32'h1, "coll_any");

        // Out-of-range address 30 (NREG=24).
        cyc();
        we[1] = 1'b1; wa[9:5] = 5'd30; wd[63:32] = 32'h77;
        sb_set = 1'b1; sb_addr = 5'd30; ra[4:0] = 5'd30;
        push_exp(0, 32'h0, "oor_no_bypass");
        push_exp(2, 32'h0, "oor_busy");
        cyc();
        idle();
        push_exp(0, 32'h0, "oor_stored");
        push_exp(2, 32'h0, "oor_busy_after");
        push_exp(4, 32'h1, "oor_any_r4");

        // Two ports writing different registers.
        cyc();
        we = 2'b11; wa[4:0] = 5'd10; wa[9:5] = 5'd11;
        wd[31:0] = 32'h10; wd[63:32] = 32'h20;
        ra[4:0] = 5'd10; ra[9:5] = 5'd11;
        cyc();
        idle();
        push_exp(0, 32'h10, "dual_r10");
        push_exp(1, 32'h20, "dual_r11");

        cyc();
        cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
